// File: rtl/quad_pkg.sv
// quad_pkg
// Shared constants and helpers for the quadrature input conditioner.
//   QD_SYNC_STAGES_DEF : default synchroniser depth per channel
//   QD_DEBOUNCE_DEF    : default number of stable cycles before a level is accepted
//   QD_ERRCNT_W        : width of the illegal-step debug counter
package quad_pkg;

    localparam int QD_SYNC_STAGES_DEF = 2;
    localparam int QD_DEBOUNCE_DEF    = 16;
    localparam int QD_ERRCNT_W        = 4;

    // Saturating increment used by the illegal-step counter so debug readout
    // pins at all-ones rather than wrapping back to a misleading small value.
    function automatic logic [QD_ERRCNT_W-1:0] sat_inc(input logic [QD_ERRCNT_W-1:0] value);
        logic [QD_ERRCNT_W-1:0] result;
        result = value;
        if (value != {QD_ERRCNT_W{1'b1}}) begin
            result = value + QD_ERRCNT_W'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// debounce_chan
// One conditioned channel: a raw asynchronous pin is passed through a flop
// synchroniser, then a new level is accepted only after it has differed from
// the current output for DEBOUNCE_CYCLES consecutive clocks.
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high reset
//   raw    : raw pin input, asynchronous to clk
//   level  : debounced, registered output level
//   toggle : high during the cycle in which level will change on the next edge
module debounce_chan
    import quad_pkg::*;
#(
    parameter int SYNC_STAGES     = QD_SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = QD_DEBOUNCE_DEF,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic toggle
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   synced;
    logic                   differ;

    // Shift chain: bit 0 captures the pin, the top bit is the metastability-safe copy.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];
    assign differ = (synced != level);

    // Flip is imminent once the disagreement has survived the full window.
    assign toggle = differ && (cnt == CNT_LAST);

    // Any cycle where the synchronised input agrees with the output discards
    // the accumulated run, so a single bounce restarts the whole window.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (!differ) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            level <= synced;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/quad_debounce.sv
// quad_debounce
// Conditions the raw A/B contacts of the quadrature encoder inputs before the
// encoder counter: per-channel synchronise + debounce, plus detection of
// illegal steps where both debounced channels change on the same edge.
// Ports:
//   clk     : system clock
//   reset   : synchronous, active-high reset
//   a_raw   : raw channel A pin, asynchronous
//   b_raw   : raw channel B pin, asynchronous
//   a_out   : debounced channel A to the encoder
//   b_out   : debounced channel B to the encoder
//   err     : one-cycle pulse, both outputs toggled on the same edge
//   err_cnt : saturating count of err pulses
module quad_debounce
    import quad_pkg::*;
#(
    parameter int SYNC_STAGES     = QD_SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = QD_DEBOUNCE_DEF,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   a_raw,
    input  logic                   b_raw,
    output logic                   a_out,
    output logic                   b_out,
    output logic                   err,
    output logic [QD_ERRCNT_W-1:0] err_cnt
);

    logic a_toggle;
    logic b_toggle;
    logic both_toggle;

    debounce_chan #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_chan_a (
        .clk    (clk),
        .reset  (reset),
        .raw    (a_raw),
        .level  (a_out),
        .toggle (a_toggle)
    );

    debounce_chan #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_chan_b (
        .clk    (clk),
        .reset  (reset),
        .raw    (b_raw),
        .level  (b_out),
        .toggle (b_toggle)
    );

    assign both_toggle = a_toggle && b_toggle;

    // err is registered on the same edge both outputs flip, so it lines up
    // with the illegal state the encoder sees. The counter advances on that
    // same edge, so it already includes the event while err is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            err <= both_toggle;
            if (both_toggle) begin
                err_cnt <= sat_inc(err_cnt);
            end
        end
    end

endmodule

// File: tb/tb_quad_debounce.sv
// tb_quad_debounce
// Self-checking bench for quad_debounce with default parameters. A window-based
// reference model decides when each output must flip: a channel flips on an
// edge when every synchronised sample in the last DEBOUNCE_CYCLES edges
// disagreed with the current output.
module tb_quad_debounce;
    import quad_pkg::*;

    localparam int SYNC = QD_SYNC_STAGES_DEF;
    localparam int DEB  = QD_DEBOUNCE_DEF;
    localparam int LAT  = SYNC + DEB - 1;
    localparam int HL   = SYNC + DEB - 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a_raw = 1'b0;
    logic       b_raw = 1'b0;
    logic       a_out;
    logic       b_out;
    logic       err;
    logic [3:0] err_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: raw samples captured on recent edges (index HL-1 newest).
    logic ha [0:HL-1];
    logic hb [0:HL-1];
    logic m_a   = 1'b0;
    logic m_b   = 1'b0;
    logic m_err = 1'b0;
    int   m_cnt = 0;

    quad_debounce dut (
        .clk     (clk),
        .reset   (reset),
        .a_raw   (a_raw),
        .b_raw   (b_raw),
        .a_out   (a_out),
        .b_out   (b_out),
        .err     (err),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    // Samples seen on the sync output over the last DEB edges are raw samples
    // taken SYNC..SYNC+DEB-1 edges ago, which are history indices 0..DEB-1.
    function automatic logic settled(input logic h [0:HL-1], input logic cur);
        logic all_diff;
        all_diff = 1'b1;
        for (int i = 0; i < DEB; i++) begin
            if (h[i] === cur) all_diff = 1'b0;
        end
        return all_diff;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < HL; i++) begin
                ha[i] <= 1'b0;
                hb[i] <= 1'b0;
            end
            m_a   <= 1'b0;
            m_b   <= 1'b0;
            m_err <= 1'b0;
            m_cnt <= 0;
        end else begin
            if (settled(ha, m_a)) m_a <= ~m_a;
            if (settled(hb, m_b)) m_b <= ~m_b;
            m_err <= settled(ha, m_a) && settled(hb, m_b);
            if (settled(ha, m_a) && settled(hb, m_b) && m_cnt < 15) m_cnt <= m_cnt + 1;
            for (int i = 0; i < HL - 1; i++) begin
                ha[i] <= ha[i+1];
                hb[i] <= hb[i+1];
            end
            ha[HL-1] <= a_raw;
            hb[HL-1] <= b_raw;
        end
    end

    // Drive one cycle of inputs and return at the following negedge.
    task automatic step(input logic a, input logic b, input logic r);
        reset = r;
        a_raw = a;
        b_raw = b;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 1'b1, 1'b1);
            n_cmp++;
            if (a_out !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_a_out cyc%0d: got %b expected 0", c, a_out); end
            n_cmp++;
            if (b_out !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_b_out cyc%0d: got %b expected 0", c, b_out); end
            n_cmp++;
            if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err cyc%0d: got %b expected 0", c, err); end
            n_cmp++;
            if (err_cnt !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_err_cnt cyc%0d: got %0d expected 0", c, err_cnt); end
        end
    endtask

    task automatic test_clean_step();
        for (int t = 0; t < 30; t++) step(1'b0, 1'b0, 1'b0);
        for (int t = 0; t < 25; t++) begin
            step(1'b1, 1'b0, 1'b0);
            n_cmp++;
            if (a_out !== (t >= LAT)) begin n_fail++; $display("[TB] FAIL step_rise_a t%0d: got %b expected %b", t, a_out, (t >= LAT)); end
            n_cmp++;
            if (b_out !== 1'b0 || err !== 1'b0) begin n_fail++; $display("[TB] FAIL step_rise_b_err t%0d: got b=%b err=%b expected 0 0", t, b_out, err); end
        end
        for (int t = 0; t < 25; t++) begin
            step(1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (a_out !== (t < LAT)) begin n_fail++; $display("[TB] FAIL step_fall_a t%0d: got %b expected %b", t, a_out, (t < LAT)); end
        end
    endtask

    task automatic test_bounce();
        for (int t = 0; t < 10; t++) begin
            step(1'b1, 1'b0, 1'b0);
            n_cmp++;
            if (a_out !== 1'b0) begin n_fail++; $display("[TB] FAIL bounce_pre t%0d: got %b expected 0", t, a_out); end
        end
        step(1'b0, 1'b0, 1'b0);
        for (int t = 0; t < 25; t++) begin
            step(1'b1, 1'b0, 1'b0);
            n_cmp++;
            if (a_out !== (t >= LAT)) begin n_fail++; $display("[TB] FAIL bounce_rise t%0d: got %b expected %b", t, a_out, (t >= LAT)); end
        end
        for (int t = 0; t < 25; t++) step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (a_out !== 1'b0) begin n_fail++; $display("[TB] FAIL bounce_settle_low: got %b expected 0", a_out); end
        for (int t = 0; t < 55; t++) begin
            step((t < DEB - 1), 1'b0, 1'b0);
            n_cmp++;
            if (a_out !== 1'b0) begin n_fail++; $display("[TB] FAIL short_pulse t%0d: got %b expected 0", t, a_out); end
        end
    endtask

    task automatic test_quadrature();
        logic [1:0] codes [0:4];
        logic [1:0] prev_code;
        logic [1:0] exp_code;
        logic [1:0] seen_prev;
        logic [1:0] seen;
        int         quarter;
        int         d;
        codes[0] = 2'b00; codes[1] = 2'b10; codes[2] = 2'b11; codes[3] = 2'b01; codes[4] = 2'b00;
        prev_code = 2'b00;
        seen_prev = {a_out, b_out};
        quarter = 0;
        for (int k = 0; k < 5; k++) begin
            for (int t = 0; t < 40; t++) begin
                step(codes[k][1], codes[k][0], 1'b0);
                exp_code = (t >= LAT) ? codes[k] : prev_code;
                seen = {a_out, b_out};
                n_cmp++;
                if (seen !== exp_code) begin n_fail++; $display("[TB] FAIL quad_seq k%0d t%0d: got %b expected %b", k, t, seen, exp_code); end
                n_cmp++;
                if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL quad_err k%0d t%0d: got %b expected 0", k, t, err); end
                if (seen !== seen_prev) begin
                    // Gray position: 00->0, 10->1, 11->2, 01->3
                    d = ((seen[1] ? (seen[0] ? 2 : 1) : (seen[0] ? 3 : 0))
                        - (seen_prev[1] ? (seen_prev[0] ? 2 : 1) : (seen_prev[0] ? 3 : 0)) + 4) % 4;
                    if (d == 1) quarter++;
                    else if (d == 3) quarter--;
                    seen_prev = seen;
                end
            end
            prev_code = codes[k];
        end
        n_cmp++;
        if (quarter / 4 != 1) begin n_fail++; $display("[TB] FAIL quad_encoder_value: got %0d expected 1", quarter / 4); end
    endtask

    task automatic test_illegal();
        logic lvl;
        int   exp_cnt;
        step(1'b0, 1'b0, 1'b1);
        for (int t = 0; t < 20; t++) step(1'b0, 1'b0, 1'b0);
        for (int ev = 1; ev <= 20; ev++) begin
            lvl = (ev % 2 == 1);
            for (int t = 0; t < 20; t++) begin
                step(lvl, lvl, 1'b0);
                n_cmp++;
                if (err !== (t == LAT)) begin n_fail++; $display("[TB] FAIL illegal_err ev%0d t%0d: got %b expected %b", ev, t, err, (t == LAT)); end
                if (t == LAT - 1) begin
                    n_cmp++;
                    if (a_out === lvl || b_out === lvl) begin n_fail++; $display("[TB] FAIL illegal_early ev%0d: got a=%b b=%b expected %b %b", ev, a_out, b_out, ~lvl, ~lvl); end
                end
                if (t == LAT) begin
                    n_cmp++;
                    if (a_out !== lvl || b_out !== lvl) begin n_fail++; $display("[TB] FAIL illegal_both ev%0d: got a=%b b=%b expected %b %b", ev, a_out, b_out, lvl, lvl); end
                end
            end
            exp_cnt = (ev > 15) ? 15 : ev;
            n_cmp++;
            if (err_cnt !== 4'(exp_cnt)) begin n_fail++; $display("[TB] FAIL illegal_cnt ev%0d: got %0d expected %0d", ev, err_cnt, exp_cnt); end
        end
    endtask

    task automatic test_reset_mid();
        for (int t = 0; t < 10; t++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (a_out !== 1'b0 || err_cnt !== 4'd0) begin n_fail++; $display("[TB] FAIL midreset_state: got a=%b cnt=%0d expected 0 0", a_out, err_cnt); end
        for (int t = 0; t < 25; t++) begin
            step(1'b1, 1'b0, 1'b0);
            n_cmp++;
            if (a_out !== (t >= LAT)) begin n_fail++; $display("[TB] FAIL midreset_rise t%0d: got %b expected %b", t, a_out, (t >= LAT)); end
        end
    endtask

    task automatic test_random();
        logic a;
        logic b;
        int   hold_a;
        int   hold_b;
        step(1'b0, 1'b0, 1'b1);
        a = 1'b0; b = 1'b0; hold_a = 5; hold_b = 9;
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 40) == 0) begin
                a = ~a; b = ~b;
                hold_a = $urandom_range(16, 40);
                hold_b = hold_a;
            end else begin
                if (hold_a == 0) begin a = ~a; hold_a = $urandom_range(1, 40); end
                if (hold_b == 0) begin b = ~b; hold_b = $urandom_range(1, 40); end
            end
            hold_a--; hold_b--;
            step(a, b, 1'b0);
            n_cmp++;
            if (a_out !== m_a) begin n_fail++; $display("[TB] FAIL rand_a t%0d: got %b expected %b", t, a_out, m_a); end
            n_cmp++;
            if (b_out !== m_b) begin n_fail++; $display("[TB] FAIL rand_b t%0d: got %b expected %b", t, b_out, m_b); end
            n_cmp++;
            if (err !== m_err) begin n_fail++; $display("[TB] FAIL rand_err t%0d: got %b expected %b", t, err, m_err); end
            n_cmp++;
            if (err_cnt !== 4'(m_cnt)) begin n_fail++; $display("[TB] FAIL rand_err_cnt t%0d: got %0d expected %0d", t, err_cnt, m_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_clean_step();
        test_bounce();
        test_quadrature();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
